// File: rtl/program_memory_arbiter_if.sv
// Bus bundle between the fetch cores / loader / program word memory and the arbiter.
interface program_memory_arbiter_if #(
    parameter int unsigned N_CORES = 4,
    parameter int unsigned IA_W    = 16,
    parameter int unsigned ID_W    = 24
);
    logic [N_CORES-1:0]      REQ;
    logic [N_CORES*IA_W-1:0] ADDR;
    logic [N_CORES-1:0]      ACK;
    logic [ID_W-1:0]         RDATA;
    logic                    LD_REQ;
    logic [IA_W-1:0]         LD_A;
    logic [ID_W-1:0]         LD_DI;
    logic                    LD_ACK;
    logic [IA_W-1:0]         MEM_A;
    logic                    MEM_WE;
    logic [ID_W-1:0]         MEM_DI;
    logic [ID_W-1:0]         MEM_DQ;
    logic [31:0]             ACC_CNT;

    // Requesters, loader and memory side
    modport master (
        output REQ, ADDR, LD_REQ, LD_A, LD_DI, MEM_DQ,
        input  ACK, RDATA, LD_ACK, MEM_A, MEM_WE, MEM_DI, ACC_CNT
    );

    // Arbiter side
    modport slave (
        input  REQ, ADDR, LD_REQ, LD_A, LD_DI, MEM_DQ,
        output ACK, RDATA, LD_ACK, MEM_A, MEM_WE, MEM_DI, ACC_CNT
    );
endinterface

// File: rtl/program_memory_arbiter.sv
// Program word memory arbiter: fixed-priority loader writes, round-robin core fetches.
// Optional completed-access counter enabled by defining PMA_ACCESS_CNT_EN.
module program_memory_arbiter #(
    parameter int unsigned N_CORES = 4,
    parameter int unsigned IA_W    = 16,
    parameter int unsigned ID_W    = 24
) (
    input  logic                      CLK,
    input  logic                      RST,
    program_memory_arbiter_if.slave   bus
);
    localparam int unsigned SEL_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               ld_sel_q, ld_sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [N_CORES-1:0] ack_q, ack_d;
    logic               ld_ack_q, ld_ack_d;
    logic [ID_W-1:0]    rdata_q, rdata_d;
    logic [IA_W-1:0]    mem_a_q, mem_a_d;
    logic               mem_we_q, mem_we_d;
    logic [ID_W-1:0]    mem_di_q, mem_di_d;

    logic [IA_W-1:0]    addr_arr [N_CORES];
    logic               grant_found;
    logic [SEL_W-1:0]   grant_idx;
    logic [SEL_W-1:0]   cand;

    for (genvar g = 0; g < N_CORES; g++) begin : g_addr
        assign addr_arr[g] = bus.ADDR[g*IA_W +: IA_W];
    end

    // First requesting core searching upward from ptr+1, wrapping modulo N_CORES
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 1; i <= N_CORES; i++) begin
            cand = SEL_W'((32'(ptr_q) + i) % N_CORES);
            if (!grant_found && bus.REQ[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        ld_sel_d = ld_sel_q;
        ptr_d    = ptr_q;
        ack_d    = '0;
        ld_ack_d = 1'b0;
        rdata_d  = rdata_q;
        mem_a_d  = mem_a_q;
        mem_we_d = 1'b0;
        mem_di_d = mem_di_q;
        case (state_q)
            S_IDLE: begin
                if (bus.LD_REQ) begin
                    mem_a_d  = bus.LD_A;
                    mem_di_d = bus.LD_DI;
                    mem_we_d = 1'b1;
                    ld_sel_d = 1'b1;
                    state_d  = S_ACCESS;
                end else if (grant_found) begin
                    sel_d    = grant_idx;
                    ld_sel_d = 1'b0;
                    mem_a_d  = addr_arr[grant_idx];
                    state_d  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // Write commits (or read data is captured) on the edge leaving this state
                if (ld_sel_q) begin
                    ld_ack_d = 1'b1;
                end else begin
                    rdata_d       = bus.MEM_DQ;
                    ack_d[sel_q]  = 1'b1;
                    ptr_d         = sel_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            ld_sel_q <= 1'b0;
            ptr_q    <= SEL_W'(N_CORES - 1);
            ack_q    <= '0;
            ld_ack_q <= 1'b0;
            rdata_q  <= '0;
            mem_a_q  <= '0;
            mem_we_q <= 1'b0;
            mem_di_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            ld_sel_q <= ld_sel_d;
            ptr_q    <= ptr_d;
            ack_q    <= ack_d;
            ld_ack_q <= ld_ack_d;
            rdata_q  <= rdata_d;
            mem_a_q  <= mem_a_d;
            mem_we_q <= mem_we_d;
            mem_di_q <= mem_di_d;
        end
    end

`ifdef PMA_ACCESS_CNT_EN
    logic [31:0] acc_cnt_q, acc_cnt_d;

    // Saturating count of completed accesses
    always_comb begin
        acc_cnt_d = acc_cnt_q;
        if (((|ack_d) || ld_ack_d) && (acc_cnt_q != 32'hFFFF_FFFF)) begin
            acc_cnt_d = acc_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_cnt_q <= '0;
        end else begin
            acc_cnt_q <= acc_cnt_d;
        end
    end

    assign bus.ACC_CNT = acc_cnt_q;
`else
    assign bus.ACC_CNT = 32'd0;
`endif

    assign bus.ACK    = ack_q;
    assign bus.LD_ACK = ld_ack_q;
    assign bus.RDATA  = rdata_q;
    assign bus.MEM_A  = mem_a_q;
    assign bus.MEM_WE = mem_we_q;
    assign bus.MEM_DI = mem_di_q;

endmodule

// File: doc/program_memory_arbiter.md
Name: program_memory_arbiter

Overview:
Shares the single-port program word memory between N_CORES instruction-fetch requesters and one loader write port. Loader writes have fixed priority. Core fetches are granted round-robin. The block sits between the cores' fetch units and the program word memory, owns the memory's A/WE/DI inputs, and returns DQ to the granted core with a one-cycle acknowledge pulse.

Parameters:
- N_CORES, 4, number of fetch requesters (2..8)
- IA_W, 16, program memory address width
- ID_W, 24, program word width (8-bit opcode + 16-bit operand)

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous reset, active-high
- REQ  in  N_CORES  per-core fetch request, level; held until ACK
- ADDR  in  N_CORES*IA_W  per-core fetch address, core i at bits [i*IA_W +: IA_W]; held while REQ is high
- ACK  out  N_CORES  one-hot, one-cycle pulse; RDATA valid in the same cycle
- RDATA  out  ID_W  fetched word, shared by all cores, registered
- LD_REQ  in  1  loader write request, level; held until LD_ACK
- LD_A  in  IA_W  loader write address
- LD_DI  in  ID_W  loader write data
- LD_ACK  out  1  one-cycle pulse when the write has been committed
- MEM_A  out  IA_W  to memory A
- MEM_WE  out  1  to memory WE
- MEM_DI  out  ID_W  to memory DI
- MEM_DQ  in  ID_W  from memory DQ (combinational read of MEM_A)
- ACC_CNT  out  32  completed-access counter (see Optional Feature)

Behaviour:
- Reset (async, RST=1) clears everything immediately:
  - state=S_IDLE; ACK=0, LD_ACK=0, RDATA=0, MEM_A=0, MEM_WE=0, MEM_DI=0, ACC_CNT=0
  - RR pointer=N_CORES-1, so core 0 wins first
- All outputs are registered. No combinational path from REQ or LD_REQ to any output.
- FSM has two states:
  - S_IDLE:
    - If LD_REQ=1: register MEM_A<=LD_A, MEM_DI<=LD_DI, MEM_WE<=1, sel=LOADER; go to S_ACCESS.
    - Else if any REQ=1: pick the first requesting core searching from ptr+1 upward, modulo N_CORES. Register sel=that index, MEM_A<=its ADDR, MEM_WE<=0; go to S_ACCESS.
    - Else stay in S_IDLE; MEM_WE=0.
  - S_ACCESS:
    - MEM_A stays stable for the whole cycle.
    - Loader: MEM_WE=1 this cycle only; write commits on this edge; next cycle LD_ACK=1, MEM_WE=0.
    - Core: RDATA<=MEM_DQ on this edge; next cycle ACK[sel]=1; ptr<=sel.
    - Always return to S_IDLE.
- Latency:
  - Request sampled at edge 0 (IDLE→ACCESS).
  - ACK or LD_ACK plus RDATA valid in the cycle after edge 1, i.e. 2 cycles after the sampling edge.
  - Peak throughput is one access per 2 cycles.
- RDATA holds its last value until the next core access completes. Loader accesses do not change RDATA.
- ACK is always one-hot or zero. ACK and LD_ACK are never high in the same cycle.
- A requester must deassert REQ, or present a new ADDR, in the cycle of its ACK. If REQ is still high at the following IDLE evaluation, it is treated as a new request.
- REQ dropped during S_ACCESS: the access completes and ACK still pulses; the requester ignores it.
- Simultaneous LD_REQ and REQ: the loader wins and the core waits. Continuous LD_REQ may starve cores; the loader is used only while the cores are halted.
- Fairness: with all N_CORES requesting continuously, each core is granted exactly once per N_CORES core grants.
- Address wrap: MEM_A passes through unmodified, including 16'hFFFF. No bounds check.
- Reset mid-access: an in-flight write is aborted (MEM_WE drops asynchronously), no ACK is issued, and the requester re-requests after reset.

Optional Feature:
- Macro: PMA_ACCESS_CNT_EN
- Defined:
  - ACC_CNT increments by 1 on every edge on which ACK or LD_ACK is registered high, i.e. once per completed access.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by RST.
- Undefined: ACC_CNT is tied to 32'd0 and no counter register is built.

Test Plan:
- Single core read: memory word 0x0003 = 24'h0A000A; REQ[0]=1, ADDR0=16'h0003 → ACK=4'b0001 exactly 2 cycles after sampling, RDATA=24'h0A000A, MEM_WE=0 throughout.
- Loader write then read: LD_REQ=1, LD_A=16'h0010, LD_DI=24'h123456 → MEM_WE high for exactly 1 cycle, LD_ACK pulse 2 cycles after sampling; then REQ[2] at 16'h0010 → ACK[2] with RDATA=24'h123456.
- Round-robin: REQ=4'b1111 held, with each core re-requesting immediately after ACK → ACK order 0,1,2,3,0,1,2,3 over 16 cycles; with PMA_ACCESS_CNT_EN, ACC_CNT=8.
- Loader priority: LD_REQ and REQ[1] asserted in the same cycle → LD_ACK first, ACK[1] 2 cycles later; ACK and LD_ACK never overlap.
- Wrap/boundary: REQ[3] at ADDR3=16'hFFFF with memory[16'hFFFF]=24'hFFFFFF → MEM_A=16'hFFFF, RDATA=24'hFFFFFF, ACK[3].
- Reset mid-operation: assert RST during the S_ACCESS cycle of a loader write → MEM_WE=0 immediately, no LD_ACK, all outputs 0; after release, REQ[0] is granted first.
